// File: rtl/pe_pkg.sv
// Shared encodings for the pe_core processing element: opcodes, namespaces,
// operand selects and the 16-bit instruction layout.
package pe_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_GT   = 3'd4,
        OP_PASS = 3'd5,
        OP_EOL  = 3'd6,
        OP_EOC  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        NS_INSTR   = 2'd0,
        NS_DATA    = 2'd1,
        NS_WEIGHT  = 2'd2,
        NS_INTERIM = 2'd3
    } ns_t;

    typedef enum logic [1:0] {
        SEL_DATA    = 2'd0,
        SEL_WEIGHT  = 2'd1,
        SEL_INTERIM = 2'd2,
        SEL_BUS     = 2'd3
    } sel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned INST_LEN      = 16;
    localparam int unsigned DATA_DEPTH    = 8;
    localparam int unsigned WEIGHT_DEPTH  = 8;
    localparam int unsigned INTERIM_DEPTH = 4;
    localparam int unsigned NUM_PORTS     = 4;

    // Field order fixes bit positions: op[15:13] dst[12:10] src1[9:5] src2[4:0]
    typedef struct packed {
        sel_t       sel;
        logic [2:0] idx;
    } src_t;

    typedef struct packed {
        op_t        op;
        logic [2:0] dst;
        src_t       src1;
        src_t       src2;
    } inst_t;

    function automatic logic uses_src1(op_t op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_GT, OP_PASS};
    endfunction

    function automatic logic uses_src2(op_t op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_GT};
    endfunction

    function automatic logic writes_result(op_t op);
        return uses_src1(op);
    endfunction

endpackage

// File: rtl/pe_alu.sv
// Combinational ALU for pe_core; arithmetic wraps at W bits, compare is unsigned.
module pe_alu
    import pe_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result_c
);

    always_comb begin
        result_c = '0;
        case (op_t'(op))
            OP_ADD:  result_c = a + b;
            OP_SUB:  result_c = a - b;
            OP_MUL:  result_c = a * b;
            OP_GT:   result_c = W'(a > b);
            OP_PASS: result_c = a;
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/pe_core.sv
// TABLA-style processing element: preloaded local namespaces, then one
// instruction per cycle with bus-operand stalls, EOL looping and EOC stop.
module pe_core
    import pe_pkg::*;
#(
    parameter int unsigned peId        = 0,
    parameter int unsigned peIdLen     = 2,
    parameter int unsigned logNumPe    = 0,
    parameter int unsigned logNumPu    = 0,
    parameter int unsigned memDataLen  = 16,
    parameter int unsigned instAddrLen = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mem_wrt_valid,
    input  logic [peIdLen-1:0]    peId_mem_in,
    input  logic [1:0]            mem_data_type,
    input  logic [memDataLen-1:0] mem_data_input,
    output logic [memDataLen-1:0] mem_data_output,
    output logic                  inst_eoc,
    output logic                  inst_eol,
    input  logic [memDataLen-1:0] pe_neigh_data_in,
    input  logic                  pe_neigh_data_in_v,
    input  logic [memDataLen-1:0] pu_neigh_data_in,
    input  logic                  pu_neigh_data_in_v,
    input  logic [memDataLen-1:0] pe_bus_data_in,
    input  logic                  pe_bus_data_in_v,
    input  logic [memDataLen-1:0] gb_bus_data_in,
    input  logic                  gb_bus_data_in_v,
    output logic [memDataLen-1:0] pe_neigh_data_out,
    output logic                  pe_neigh_data_out_v,
    output logic [memDataLen-1:0] pu_neigh_data_out,
    output logic                  pu_neigh_data_out_v,
    output logic [memDataLen-1:0] pe_bus_data_out,
    output logic                  pe_bus_data_out_v,
    output logic [memDataLen-1:0] gb_bus_data_out,
    output logic                  gb_bus_data_out_v
);

    localparam int unsigned W          = memDataLen;
    localparam int unsigned IMEM_DEPTH = 1 << instAddrLen;

    if (memDataLen < INST_LEN || logNumPe + logNumPu > 16) begin : g_cfg_check
        $error("pe_core: memDataLen must be at least 16 and PE/PU counts sane");
    end

    state_t                 state, state_n;
    logic [instAddrLen-1:0] pc, pc_n;
    logic                   eoc_n;

    logic [W-1:0] imem    [IMEM_DEPTH];
    logic [W-1:0] dmem    [DATA_DEPTH];
    logic [W-1:0] wmem    [WEIGHT_DEPTH];
    logic [W-1:0] interim [INTERIM_DEPTH];

    logic [instAddrLen-1:0] iptr;
    logic [2:0]             dptr, wptr;
    logic [1:0]             tptr;

    logic [W-1:0]         bus_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] bus_v;
    logic [W-1:0]         out_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] out_v;

    inst_t        inst;
    src_t         src   [2];
    logic [W-1:0] opnd  [2];
    logic [1:0]   used, blocked;
    logic [W-1:0] alu_res;
    logic         stall_c, exec_c, eol_c, wr_int_c, wr_out_c, pre_wr_c;

    assign inst   = inst_t'(imem[pc][INST_LEN-1:0]);
    assign src[0] = inst.src1;
    assign src[1] = inst.src2;
    assign used   = {uses_src2(inst.op), uses_src1(inst.op)};

    assign bus_data[0] = pe_neigh_data_in;
    assign bus_data[1] = pu_neigh_data_in;
    assign bus_data[2] = pe_bus_data_in;
    assign bus_data[3] = gb_bus_data_in;
    assign bus_v       = {gb_bus_data_in_v, pe_bus_data_in_v, pu_neigh_data_in_v, pe_neigh_data_in_v};

    // Operand fetch; a used bus operand without valid blocks the instruction
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            opnd[i]    = '0;
            blocked[i] = 1'b0;
            case (src[i].sel)
                SEL_DATA:    opnd[i] = dmem[src[i].idx];
                SEL_WEIGHT:  opnd[i] = wmem[src[i].idx];
                SEL_INTERIM: opnd[i] = interim[src[i].idx[1:0]];
                default: begin
                    opnd[i]    = bus_data[src[i].idx[1:0]];
                    blocked[i] = used[i] && !bus_v[src[i].idx[1:0]];
                end
            endcase
        end
    end

    assign stall_c  = |blocked;
    assign pre_wr_c = mem_wrt_valid && (peId_mem_in == peIdLen'(peId)) && (state == ST_IDLE);

    pe_alu #(.W(W)) u_alu (
        .op       (inst.op),
        .a        (opnd[0]),
        .b        (opnd[1]),
        .result_c (alu_res)
    );

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        eoc_n    = inst_eoc;
        exec_c   = 1'b0;
        eol_c    = 1'b0;
        wr_int_c = 1'b0;
        wr_out_c = 1'b0;
        if (start) begin
            state_n = ST_RUN;
            pc_n    = '0;
            eoc_n   = 1'b0;
        end else if (state == ST_RUN && !stall_c) begin
            exec_c   = 1'b1;
            pc_n     = pc + instAddrLen'(1);
            wr_int_c = writes_result(inst.op) && !inst.dst[2];
            wr_out_c = writes_result(inst.op) && inst.dst[2];
            case (inst.op)
                OP_EOL: begin
                    pc_n  = '0;
                    eol_c = 1'b1;
                end
                OP_EOC: begin
                    state_n = ST_IDLE;
                    eoc_n   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            inst_eoc <= 1'b0;
            inst_eol <= 1'b0;
            out_v    <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            inst_eoc <= eoc_n;
            inst_eol <= eol_c;
            out_v    <= '0;
            if (wr_out_c) out_v[inst.dst[1:0]] <= 1'b1;
        end
    end

    // Namespace pointers, interim registers and output data
    always_ff @(posedge clk) begin
        if (reset) begin
            iptr     <= '0;
            dptr     <= '0;
            wptr     <= '0;
            tptr     <= '0;
            interim  <= '{default: '0};
            out_data <= '{default: '0};
        end else begin
            if (pre_wr_c) begin
                case (ns_t'(mem_data_type))
                    NS_INSTR:  iptr <= iptr + instAddrLen'(1);
                    NS_DATA:   dptr <= dptr + 3'd1;
                    NS_WEIGHT: wptr <= wptr + 3'd1;
                    NS_INTERIM: begin
                        interim[tptr] <= mem_data_input;
                        tptr          <= tptr + 2'd1;
                    end
                endcase
            end
            if (wr_int_c) interim[inst.dst[1:0]] <= alu_res;
            if (wr_out_c) out_data[inst.dst[1:0]] <= alu_res;
        end
    end

    // Instruction, data and weight contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && pre_wr_c) begin
            case (ns_t'(mem_data_type))
                NS_INSTR:  imem[iptr] <= mem_data_input;
                NS_DATA:   dmem[dptr] <= mem_data_input;
                NS_WEIGHT: wmem[wptr] <= mem_data_input;
                default: ;
            endcase
        end
    end

    assign mem_data_output     = interim[0];
    assign pe_neigh_data_out   = out_data[0];
    assign pu_neigh_data_out   = out_data[1];
    assign pe_bus_data_out     = out_data[2];
    assign gb_bus_data_out     = out_data[3];
    assign pe_neigh_data_out_v = out_v[0];
    assign pu_neigh_data_out_v = out_v[1];
    assign pe_bus_data_out_v   = out_v[2];
    assign gb_bus_data_out_v   = out_v[3];

endmodule

// File: tb/tb_pe_core.sv
// Scoreboard bench for pe_core: an instruction-level reference model predicts
// port transactions and per-cycle state, a negedge monitor compares them.
module tb_pe_core;

    localparam int DEPTH = 32;
    localparam logic [1:0] PE_ID  = 2'd1;
    localparam logic [1:0] BAD_ID = 2'd2;
    localparam int OP_NOP = 0, OP_ADD = 1, OP_SUB = 2, OP_MUL = 3;
    localparam int OP_GT = 4, OP_PASS = 5, OP_EOL = 6, OP_EOC = 7;
    localparam int S_D = 0, S_W = 8, S_I = 16, S_B = 24;

    logic        clk = 1'b0;
    logic        rst, start, wr_v;
    logic [1:0]  wr_id, wr_type;
    logic [15:0] wr_data;
    logic [15:0] bus_d [4];
    logic [3:0]  bus_v;
    logic [15:0] od [4];
    logic [3:0]  ov;
    logic [15:0] mdo;
    logic        eoc, eol;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_core #(.peId(1), .peIdLen(2), .logNumPe(0), .logNumPu(0), .memDataLen(16), .instAddrLen(5)) dut (
        .clk(clk), .reset(rst), .start(start), .mem_wrt_valid(wr_v), .peId_mem_in(wr_id),
        .mem_data_type(wr_type), .mem_data_input(wr_data), .mem_data_output(mdo),
        .inst_eoc(eoc), .inst_eol(eol),
        .pe_neigh_data_in(bus_d[0]), .pe_neigh_data_in_v(bus_v[0]),
        .pu_neigh_data_in(bus_d[1]), .pu_neigh_data_in_v(bus_v[1]),
        .pe_bus_data_in(bus_d[2]),   .pe_bus_data_in_v(bus_v[2]),
        .gb_bus_data_in(bus_d[3]),   .gb_bus_data_in_v(bus_v[3]),
        .pe_neigh_data_out(od[0]), .pe_neigh_data_out_v(ov[0]),
        .pu_neigh_data_out(od[1]), .pu_neigh_data_out_v(ov[1]),
        .pe_bus_data_out(od[2]),   .pe_bus_data_out_v(ov[2]),
        .gb_bus_data_out(od[3]),   .gb_bus_data_out_v(ov[3])
    );

    // Reference model state
    logic [15:0] m_imem [DEPTH];
    logic [15:0] m_data [8];
    logic [15:0] m_wt   [8];
    logic [15:0] m_int  [4];
    int m_iptr, m_dptr, m_wptr, m_tptr, m_pc;
    bit m_run, m_eoc;

    typedef struct { int port; logic [15:0] data; int at; } out_ev_t;
    typedef struct { logic [15:0] mdo; logic eoc; logic eol; int at; } snap_t;
    out_ev_t exp_out[$];
    snap_t   exp_snap[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit fetch(input logic [4:0] s, output logic [15:0] v);
        int idx = int'(s[2:0]);
        case (int'(s[4:3]))
            0: v = m_data[idx];
            1: v = m_wt[idx];
            2: v = m_int[idx % 4];
            default: begin
                v = bus_d[idx % 4];
                return bus_v[idx % 4];
            end
        endcase
        return 1'b1;
    endfunction

    // Predict the effect of the cycle whose inputs are currently driven
    task automatic model_step();
        int nc = cyc + 1;
        logic [15:0] w, a, b, r;
        int op, dst;
        bit ok1, ok2, ev_eol;
        ev_eol = 1'b0;
        if (rst) begin
            m_run = 0; m_pc = 0; m_eoc = 0;
            m_iptr = 0; m_dptr = 0; m_wptr = 0; m_tptr = 0;
            for (int i = 0; i < 4; i++) m_int[i] = '0;
        end else begin
            if (wr_v && wr_id == PE_ID && !m_run) begin
                case (int'(wr_type))
                    0: begin m_imem[m_iptr] = wr_data; m_iptr = (m_iptr + 1) % DEPTH; end
                    1: begin m_data[m_dptr] = wr_data; m_dptr = (m_dptr + 1) % 8; end
                    2: begin m_wt[m_wptr]   = wr_data; m_wptr = (m_wptr + 1) % 8; end
                    default: begin m_int[m_tptr] = wr_data; m_tptr = (m_tptr + 1) % 4; end
                endcase
            end
            if (start) begin
                m_run = 1; m_pc = 0; m_eoc = 0;
            end else if (m_run) begin
                w   = m_imem[m_pc];
                op  = int'(w[15:13]);
                dst = int'(w[12:10]);
                ok1 = fetch(w[9:5], a);
                ok2 = fetch(w[4:0], b);
                if (!((op >= OP_ADD && op <= OP_PASS && !ok1) || (op >= OP_ADD && op <= OP_GT && !ok2))) begin
                    m_pc = (m_pc + 1) % DEPTH;
                    r = '0;
                    case (op)
                        OP_ADD:  r = 16'((int'(a) + int'(b)) % 65536);
                        OP_SUB:  r = 16'((int'(a) - int'(b) + 65536) % 65536);
                        OP_MUL:  r = 16'((longint'(a) * longint'(b)) % 65536);
                        OP_GT:   r = (a > b) ? 16'd1 : 16'd0;
                        OP_PASS: r = a;
                        OP_EOL:  begin ev_eol = 1'b1; m_pc = 0; end
                        OP_EOC:  begin m_run = 0; m_eoc = 1; end
                        default: ;
                    endcase
                    if (op >= OP_ADD && op <= OP_PASS) begin
                        if (dst < 4) m_int[dst] = r;
                        else exp_out.push_back('{dst - 4, r, nc});
                    end
                end
            end
        end
        exp_snap.push_back('{m_int[0], m_eoc, ev_eol, nc});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        wr_v  = 1'b0;
    endtask

    task automatic preload(input int t, input logic [15:0] d, input logic [1:0] id);
        wr_v = 1'b1; wr_type = 2'(t); wr_data = d; wr_id = id;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
    endtask

    function automatic logic [15:0] enc(input int op, input int dst, input int s1, input int s2);
        return {3'(op), 3'(dst), 5'(s1), 5'(s2)};
    endfunction

    task automatic randomize_bus();
        for (int i = 0; i < 4; i++) begin
            bus_v[i] = ($urandom_range(0, 3) != 0);
            bus_d[i] = 16'($urandom);
        end
    endtask

    task automatic run_prog(input int budget, input bit rand_bus);
        start = 1'b1;
        tick();
        for (int i = 0; i < budget && m_run; i++) begin
            if (rand_bus) randomize_bus();
            tick();
        end
        check("eoc_after_program", {31'b0, eoc}, 32'd1);
    endtask

    // Monitor: per-cycle state snapshot plus valid-driven port transactions
    always @(negedge clk) begin
        snap_t   s;
        out_ev_t e;
        if (exp_snap.size() > 0 && exp_snap[0].at == cyc) begin
            s = exp_snap.pop_front();
            check("mem_data_output", {16'b0, mdo}, {16'b0, s.mdo});
            check("inst_eoc", {31'b0, eoc}, {31'b0, s.eoc});
            check("inst_eol", {31'b0, eol}, {31'b0, s.eol});
        end
        for (int p = 0; p < 4; p++) begin
            if (ov[p] !== 1'b0) begin
                if (exp_out.size() == 0) begin
                    check("out_valid_unexpected", {31'b0, ov[p]}, 32'd0);
                end else begin
                    e = exp_out.pop_front();
                    check("out_port", p, e.port);
                    check("out_data", {16'b0, od[p]}, {16'b0, e.data});
                    check("out_cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int len;
        rst = 1'b1; start = 1'b0; wr_v = 1'b0; wr_id = '0; wr_type = '0; wr_data = '0;
        for (int i = 0; i < 4; i++) begin bus_d[i] = '0; bus_v[i] = 1'b1; end
        tick();
        check("reset_mdo", {16'b0, mdo}, 32'd0);
        check("reset_eoc", {31'b0, eoc}, 32'd0);
        check("reset_eol", {31'b0, eol}, 32'd0);
        check("reset_out_v", {28'b0, ov}, 32'd0);

        // Basic ADD then EOC
        preload(1, 16'd3, PE_ID);
        preload(2, 16'd5, PE_ID);
        preload(0, enc(OP_ADD, 0, S_D + 0, S_W + 0), PE_ID);
        preload(0, enc(OP_EOC, 0, 0, 0), PE_ID);
        start = 1'b1;
        tick();
        check("t1_eoc_cleared", {31'b0, eoc}, 32'd0);
        tick();
        check("t1_add_result", {16'b0, mdo}, 32'd8);
        tick();
        check("t1_eoc_set", {31'b0, eoc}, 32'd1);
        tick(); tick();
        check("t1_eoc_held", {31'b0, eoc}, 32'd1);

        // MUL wrap, SUB wrap, GT, observed through ports
        do_reset();
        preload(3, 16'h5A5A, PE_ID);
        preload(1, 16'h0100, PE_ID);
        preload(1, 16'd2, PE_ID);
        preload(1, 16'd3, PE_ID);
        preload(1, 16'd7, PE_ID);
        preload(2, 16'h0100, PE_ID);
        preload(0, enc(OP_MUL, 0, S_D + 0, S_W + 0), PE_ID);
        preload(0, enc(OP_SUB, 1, S_D + 1, S_D + 2), PE_ID);
        preload(0, enc(OP_GT, 2, S_D + 3, S_D + 2), PE_ID);
        preload(0, enc(OP_PASS, 4, S_I + 1, 0), PE_ID);
        preload(0, enc(OP_PASS, 5, S_I + 2, 0), PE_ID);
        preload(0, enc(OP_EOC, 0, 0, 0), PE_ID);
        run_prog(40, 1'b0);
        check("t2_mul_wrap", {16'b0, mdo}, 32'd0);
        check("t2_sub_wrap", {16'b0, od[0]}, 32'h0000FFFF);
        check("t2_gt", {16'b0, od[1]}, 32'd1);

        // Stall on pe_neigh until valid, then forward to gb_bus
        do_reset();
        preload(0, enc(OP_PASS, 7, S_B + 0, 0), PE_ID);
        preload(0, enc(OP_EOC, 0, 0, 0), PE_ID);
        bus_v[0] = 1'b0;
        start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_no_out_while_stalled", {28'b0, ov}, 32'd0);
        end
        bus_v[0] = 1'b1; bus_d[0] = 16'h1234;
        tick();
        check("t3_gb_valid", {31'b0, ov[3]}, 32'd1);
        check("t3_gb_data", {16'b0, od[3]}, 32'h1234);
        bus_v[0] = 1'b0;
        tick();
        check("t3_gb_valid_one_cycle", {31'b0, ov[3]}, 32'd0);
        check("t3_eoc", {31'b0, eoc}, 32'd1);
        bus_v[0] = 1'b1;

        // Accumulate loop with EOL; preload while running is ignored
        do_reset();
        preload(1, 16'd1, PE_ID);
        preload(0, enc(OP_ADD, 0, S_I + 0, S_D + 0), PE_ID);
        preload(0, enc(OP_EOL, 0, 0, 0), PE_ID);
        start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        preload(1, 16'h00AA, PE_ID);
        for (int i = 0; i < 5; i++) tick();
        check("t4_accum", {16'b0, mdo}, 32'd5);

        // Reset mid-run returns to idle with cleared outputs
        do_reset();
        check("t6_mdo_cleared", {16'b0, mdo}, 32'd0);
        check("t6_eol_cleared", {31'b0, eol}, 32'd0);
        check("t6_eoc_cleared", {31'b0, eoc}, 32'd0);
        tick();
        check("t6_idle", {16'b0, mdo}, 32'd0);

        // Fresh preload from pointer 0; wrong id ignored; 9th data write wraps
        preload(0, enc(OP_PASS, 6, S_D + 0, 0), PE_ID);
        preload(0, enc(OP_EOC, 0, 0, 0), PE_ID);
        preload(1, 16'h5555, BAD_ID);
        for (int i = 0; i < 9; i++) preload(1, 16'(16'h10 + i), PE_ID);
        run_prog(20, 1'b0);
        check("t5_wrap_data0", {16'b0, od[2]}, 32'h0018);

        // Randomized programs with random bus valids
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < 8; i++) preload(1, 16'($urandom), PE_ID);
            for (int i = 0; i < 8; i++) preload(2, 16'($urandom), PE_ID);
            for (int i = 0; i < 4; i++) preload(3, 16'($urandom), PE_ID);
            len = int'($urandom_range(3, 12));
            for (int i = 0; i < len; i++)
                preload(0, enc(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
                               int'($urandom_range(0, 31)), int'($urandom_range(0, 31))), PE_ID);
            preload(0, enc(OP_EOC, 0, 0, 0), PE_ID);
            run_prog(300, 1'b1);
            check("rand_interim0", {16'b0, mdo}, {16'b0, m_int[0]});
            for (int i = 0; i < 4; i++) bus_v[i] = 1'b1;
        end

        tick(); tick();
        @(negedge clk);
        #1;
        check("out_queue_drained", exp_out.size(), 32'd0);
        check("snap_queue_drained", exp_snap.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
